// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus types for the cbus round-robin arbiter and its helpers.
package cbus_rr_arbiter_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} cbus_size_t;

  // Encoded as beats-1 so that a burst carries len+1 beats.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        okay;
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // a + b modulo n, for a, b already in [0, n).
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Round-robin picker: first valid index at or after ptr, wrapping at NUM_REQ.
module rr_pick
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_BIT = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_BIT-1:0] ptr,
  output logic               found,
  output logic [IDX_BIT-1:0] idx
);

  logic [NUM_REQ-1:0] rot;
  int                 sel;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) rot[i] = valid[wrap_add(i, int'(ptr), NUM_REQ)];
    sel = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) sel = i;
    end
    found = |rot;
    idx   = IDX_BIT'(wrap_add(sel, int'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cache bus between NUM_REQ masters, one grant per burst.
//   state | meaning
//   IDLE  | no grant; pick next master from rr_ptr, outputs all zero
//   BUSY  | owner's request passed to the bridge, bridge response routed to owner
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_BIT = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  cbus_req_t          ireqs  [NUM_REQ],
  output cbus_resp_t         oresps [NUM_REQ],
  output cbus_req_t          oreq,
  input  cbus_resp_t         iresp,
  output logic               busy,
  output logic [IDX_BIT-1:0] owner
);

  arb_state_t         state, state_nxt;
  logic [IDX_BIT-1:0] owner_nxt, rr_ptr, rr_ptr_nxt, owner_wrap;
  logic [7:0]         beat_cnt, beat_nxt, beat_inc;
  logic [NUM_REQ-1:0] req_valid;
  logic               pick_found;
  logic [IDX_BIT-1:0] pick_idx;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ireqs[i].valid;
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BIT(IDX_BIT)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign beat_inc   = (beat_cnt == 8'hff) ? beat_cnt : beat_cnt + 8'd1;
  assign owner_wrap = (int'(owner) == NUM_REQ - 1) ? '0 : owner + IDX_BIT'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    beat_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BUSY;
          owner_nxt = pick_idx;
          beat_nxt  = '0;
        end
      end
      BUSY: begin
        // A last flag without ready is not a completed beat; the grant holds.
        if (iresp.ready) begin
          beat_nxt = beat_inc;
          if (iresp.last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = owner_wrap;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

  always_comb begin
    oreq = '0;
    if (busy) oreq = ireqs[owner];
    for (int i = 0; i < NUM_REQ; i++) begin
      oresps[i] = '0;
      if (busy && owner == IDX_BIT'(i)) oresps[i] = iresp;
    end
  end

  // Master protocol checks; no functional effect on the grant.
  a_beat_count: assert property (@(posedge clk) disable iff (reset)
    (busy && iresp.ready && iresp.last) |-> (beat_inc == 8'(oreq.len) + 8'd1));
  a_valid_held: assert property (@(posedge clk) disable iff (reset)
    busy |-> oreq.valid);
  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (busy && $past(busy)) |-> $stable(oreq));

endmodule
